// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared geometry helpers for the pipelined integer square root (sqrt_pipe_hs).
//   sqrt_out_width(w)          : root width for a w-bit radicand, ceil(w/2)
//   sqrt_stages(w, ips)        : number of pipeline registers for ips
//                                iterations per stage
//   sqrt_stage_iters(wo,ips,k) : iterations performed by stage k (the last
//                                stage takes whatever is left over)
// -----------------------------------------------------------------------------
package sqrt_pkg;

  function automatic int sqrt_out_width(input int w);
    return (w + 1) / 2;
  endfunction

  function automatic int sqrt_stages(input int w, input int ips);
    return (sqrt_out_width(w) + ips - 1) / ips;
  endfunction

  function automatic int sqrt_stage_iters(input int wo, input int ips, input int k);
    int left;
    left = wo - k * ips;
    return (left < ips) ? left : ips;
  endfunction

endpackage

// File: rtl/sqrt_pipe_stage.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_stage
// One register slice of the square-root pipeline: ITERS restoring
// digit-recurrence iterations (two radicand bits each, MSB first) followed by
// the payload register. The stage loads whenever i_adv is high; otherwise
// every field holds.
// Optional macro SQRT_PIPE_ROUND_EN: the last stage rounds the root half-up
// (saturating) before registering it; the remainder stays the floor one.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_adv                 stage may load (empty or its successor advances)
//   i_valid, i_root,
//   i_rem, i_rad, i_tag   payload from the previous stage / block input
//   o_valid, o_root,
//   o_rem, o_rad, o_tag   registered payload of this stage
// -----------------------------------------------------------------------------
module sqrt_pipe_stage #(
  parameter int WO      = 8,
  parameter int ITERS   = 1,
  parameter int TW      = 1,
  parameter bit IS_LAST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_adv,
  input  logic            i_valid,
  input  logic [WO-1:0]   i_root,
  input  logic [WO+1:0]   i_rem,
  input  logic [2*WO-1:0] i_rad,
  input  logic [TW-1:0]   i_tag,
  output logic            o_valid,
  output logic [WO-1:0]   o_root,
  output logic [WO+1:0]   o_rem,
  output logic [2*WO-1:0] o_rad,
  output logic [TW-1:0]   o_tag
);

  localparam int SW = 2 * WO;
  localparam int RW = WO + 2;

  logic [WO-1:0] w_root;
  logic [WO-1:0] w_root_out;
  logic [RW-1:0] w_rem;
  logic [SW-1:0] w_rad;
  logic [RW+1:0] w_sh;
  logic [RW+1:0] w_trial;
  logic [RW+1:0] w_diff;

  logic          r_valid;
  logic [WO-1:0] r_root;
  logic [RW-1:0] r_rem;
  logic [SW-1:0] r_rad;
  logic [TW-1:0] r_tag;

  // Restoring recurrence. The partial remainder never exceeds twice the
  // partial root, so dropping the top two bits of the shifted remainder
  // or of the difference never loses information.
  always_comb begin
    w_root  = i_root;
    w_rem   = i_rem;
    w_rad   = i_rad;
    w_sh    = '0;
    w_trial = '0;
    w_diff  = '0;
    for (int i = 0; i < ITERS; i++) begin
      w_sh    = {w_rem, w_rad[SW-1 -: 2]};
      w_trial = {2'b00, w_root, 2'b01};
      w_diff  = w_sh - w_trial;
      w_rad   = w_rad << 2;
      w_root  = w_root << 1;
      if (w_sh >= w_trial) begin
        w_rem     = w_diff[RW-1:0];
        w_root[0] = 1'b1;
      end else begin
        w_rem = w_sh[RW-1:0];
      end
    end
  end

`ifdef SQRT_PIPE_ROUND_EN
  // Round half-up: rem > root means radicand >= (root + 0.5)^2 in integers.
  // An all-ones root stays put rather than wrapping.
  always_comb begin
    w_root_out = w_root;
    if (IS_LAST && ({2'b00, w_root} < w_rem) && !(&w_root)) begin
      w_root_out = w_root + WO'(1);
    end
  end
`else
  assign w_root_out = w_root;
`endif

  // ---- stage register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_root  <= '0;
      r_rem   <= '0;
      r_rad   <= '0;
      r_tag   <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_root  <= w_root_out;
      r_rem   <= w_rem;
      // every radicand bit has been consumed once the last stage is reached
      r_rad   <= IS_LAST ? '0 : w_rad;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_root  = r_root;
  assign o_rem   = r_rem;
  assign o_rad   = r_rad;
  assign o_tag   = r_tag;

endmodule

// File: rtl/sqrt_pipe_hs.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_hs
// Pipelined integer square root with ready/valid handshakes and bubble
// collapsing. Returns floor(sqrt(radicand)) and radicand - root^2, plus the
// sideband tag that travelled with the operand. Latency is STAGES cycles,
// throughput one result per cycle.
// Optional macro SQRT_PIPE_ROUND_EN: out_root is rounded half-up (saturating);
// out_rem still reports the floor remainder.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       radicand offered
//   in_ready       block accepts (combinational from out_ready and valid bits)
//   in_radicand    unsigned operand, WIDTH_INPUT bits
//   in_tag         sideband tag, TAG_WIDTH bits
//   out_valid      result available
//   out_ready      consumer accepts
//   out_root       root, ceil(WIDTH_INPUT/2) bits
//   out_rem        floor remainder, one bit wider than the root
//   out_tag        tag of the returned operand
// -----------------------------------------------------------------------------
module sqrt_pipe_hs
  import sqrt_pkg::*;
#(
  parameter int WIDTH_INPUT     = 16,
  parameter int ITERS_PER_STAGE = 1,
  parameter int TAG_WIDTH       = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH_INPUT-1:0]                in_radicand,
  input  logic [TAG_WIDTH-1:0]                  in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [sqrt_out_width(WIDTH_INPUT)-1:0] out_root,
  output logic [sqrt_out_width(WIDTH_INPUT):0]   out_rem,
  output logic [TAG_WIDTH-1:0]                  out_tag
);

  localparam int WIDTH_OUTPUT = sqrt_out_width(WIDTH_INPUT);
  localparam int STAGES       = sqrt_stages(WIDTH_INPUT, ITERS_PER_STAGE);
  localparam int SW           = 2 * WIDTH_OUTPUT;
  localparam int RW           = WIDTH_OUTPUT + 2;

  // Index 0 is the block input; index k+1 is the register of stage k.
  logic [STAGES:0]         w_vld;
  logic [STAGES:0]         w_adv;
  logic [WIDTH_OUTPUT-1:0] w_root [0:STAGES];
  logic [RW-1:0]           w_rem  [0:STAGES];
  logic [SW-1:0]           w_rad  [0:STAGES];
  logic [TAG_WIDTH-1:0]    w_tag  [0:STAGES];
  logic [SW-1:0]           w_rad_in;

  // Odd radicand widths get one zero bit on top so bits pair up evenly.
  always_comb begin
    w_rad_in                  = '0;
    w_rad_in[WIDTH_INPUT-1:0] = in_radicand;
  end

  assign w_vld[0]  = in_valid;
  assign w_root[0] = '0;
  assign w_rem[0]  = '0;
  assign w_rad[0]  = w_rad_in;
  assign w_tag[0]  = in_tag;

  // Advance chain, resolved from the output end: a stage may load when it is
  // empty or when its contents move on. w_adv[k] is the load enable of stage
  // k; w_adv[STAGES] is the output handshake.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = !w_vld[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !w_vld[k+1] || w_adv[k+1];
    end
  end

  assign in_ready = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int NIT = sqrt_stage_iters(WIDTH_OUTPUT, ITERS_PER_STAGE, k);
    sqrt_pipe_stage #(
      .WO      (WIDTH_OUTPUT),
      .ITERS   (NIT),
      .TW      (TAG_WIDTH),
      .IS_LAST (k == STAGES - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv[k]),
      .i_valid (w_vld[k]),
      .i_root  (w_root[k]),
      .i_rem   (w_rem[k]),
      .i_rad   (w_rad[k]),
      .i_tag   (w_tag[k]),
      .o_valid (w_vld[k+1]),
      .o_root  (w_root[k+1]),
      .o_rem   (w_rem[k+1]),
      .o_rad   (w_rad[k+1]),
      .o_tag   (w_tag[k+1])
    );
  end

  // The final stage registers are the outputs; the remainder fits one bit
  // above the root width.
  assign out_valid = w_vld[STAGES];
  assign out_root  = w_root[STAGES];
  assign out_rem   = w_rem[STAGES][WIDTH_OUTPUT:0];
  assign out_tag   = w_tag[STAGES];

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
module tb_sqrt_pipe_hs;

  localparam int STAGES   = 8;
  localparam int B_STAGES = 3;

`ifdef SQRT_PIPE_ROUND_EN
  localparam int R528   = 23;
  localparam int R507   = 23;
  localparam int R16383 = 128;
`else
  localparam int R528   = 22;
  localparam int R507   = 22;
  localparam int R16383 = 127;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_radicand = '0;
  logic [9:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_root;
  logic [8:0]  out_rem;
  logic [9:0]  out_tag;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [14:0] b_in_radicand = '0;
  logic [0:0]  b_in_tag = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [7:0]  b_out_root;
  logic [8:0]  b_out_rem;
  logic [0:0]  b_out_tag;

  always #5 clk = ~clk;

  sqrt_pipe_hs #(.WIDTH_INPUT(16), .ITERS_PER_STAGE(1), .TAG_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_radicand(in_radicand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
    .out_tag(out_tag)
  );

  sqrt_pipe_hs #(.WIDTH_INPUT(15), .ITERS_PER_STAGE(3), .TAG_WIDTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_radicand(b_in_radicand), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_root(b_out_root), .out_rem(b_out_rem),
    .out_tag(b_out_tag)
  );

  typedef struct packed {
    logic [7:0] root;
    logic [8:0] rem;
    logic [9:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor root by counting, remainder from the floor root,
  // then optional half-up rounding with saturation.
  task automatic model(input int x, output int r, output int m);
    int root;
    root = 0;
    while ((root + 1) * (root + 1) <= x) root++;
    m = x - root * root;
`ifdef SQRT_PIPE_ROUND_EN
    if (m > root && root < 255) root++;
`endif
    r = root;
  endtask

  // Offer one operand; push its expectation at the accepting edge.
  task automatic send_exp(input int rad, input int tag, input int er, input int em);
    int w;
    exp_t e;
    in_valid    = 1'b1;
    in_radicand = 16'(rad);
    in_tag      = 10'(tag);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for radicand %0d", rad);
    end else begin
      e.root = 8'(er);
      e.rem  = 9'(em);
      e.tag  = 10'(tag);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input int rad, input int tag);
    int r, m;
    model(rad, r, m);
    send_exp(rad, tag, r, m);
  endtask

  // Called #1 after the accepting edge; counts edges up to first out_valid.
  task automatic check_latency(input string name, input int exp);
    int n;
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, exp);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk(name, sb_q.size(), 0);
  endtask

  task automatic bsend(input int rad, input int tag, input int er, input int em);
    int n;
    b_in_valid    = 1'b1;
    b_in_radicand = 15'(rad);
    b_in_tag      = 1'(tag);
    @(negedge clk);
    chk("b_in_ready", int'(b_in_ready), 1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_latency", n, B_STAGES);
    chk("b_root", int'(b_out_root), er);
    chk("b_rem", int'(b_out_rem), em);
    chk("b_tag", int'(b_out_tag), tag);
  endtask

  // Scoreboard monitor: pops on every output handshake and checks that a
  // stalled output holds every field.
  logic stall_prev = 1'b0;
  logic [7:0] snap_root;
  logic [8:0] snap_rem;
  logic [9:0] snap_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: root %0d rem %0d tag %0d with empty queue",
                 out_root, out_rem, out_tag);
      end else begin
        e = sb_q.pop_front();
        chk("out_root", int'(out_root), int'(e.root));
        chk("out_rem", int'(out_rem), int'(e.rem));
        chk("out_tag", int'(out_tag), int'(e.tag));
      end
    end
    if (rst_n && stall_prev) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_root", int'(out_root), int'(snap_root));
      chk("stall_rem", int'(out_rem), int'(snap_rem));
      chk("stall_tag", int'(out_tag), int'(snap_tag));
    end
    stall_prev = rst_n && out_valid && !out_ready;
    snap_root  = out_root;
    snap_rem   = out_rem;
    snap_tag   = out_tag;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, seen, t0, r, m;
    bit rnd_done;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_root", int'(out_root), 0);
    chk("rst_out_rem", int'(out_rem), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // first acceptance to first out_valid
    out_ready = 1'b1;
    send_exp(0, 0, 0, 0);
    check_latency("latency_first", STAGES);
    drain("drain_first");

    // sweep 0..1023 back to back; one accept per cycle with full pipe
    t0 = int'($time);
    for (int i = 0; i < 1024; i++) begin
      if (i == 484)      send_exp(i, i, 22, 0);
      else if (i == 528) send_exp(i, i, R528, 44);
      else if (i == 529) send_exp(i, i, 23, 0);
      else               send(i, i);
    end
    chk("sweep_cycles", (int'($time) - t0) / 10, 1024);
    drain("drain_sweep");

    // edge operands
    send_exp(65535, 1, 255, 510);
    send_exp(506, 2, 22, 22);
    send_exp(507, 3, R507, 23);
    send_exp(0, 4, 0, 0);
    drain("drain_edges");

    // backpressure: the pipe holds one operand per stage register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_radicand = 16'(1000 + acc * 37);
      in_tag      = 10'(100 + acc);
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        model(1000 + acc * 37, r, m);
        e.root = 8'(r);
        e.rem  = 9'(m);
        e.tag  = 10'(100 + acc);
        sb_q.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", acc, STAGES);
    chk("bp_in_ready", int'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_bp");

    // random bubbles on both sides
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          for (int k = 0; k < 8 && ($urandom_range(0, 1) == 1); k++) begin
            @(posedge clk);
            #1;
          end
          send(int'($urandom_range(0, 65535)), i % 1024);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    // reset with five operands in flight
    for (int i = 0; i < 5; i++) send(200 + i, 300 + i);
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst2_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < STAGES + 4; c++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("rst2_no_stale", seen, 0);
    send_exp(100, 5, 10, 0);
    check_latency("latency_after_rst", STAGES);
    drain("drain_rst");

    // odd width, three iterations per stage
    bsend(32767, 1, 181, 6);
    bsend(16383, 0, R16383, 254);
    bsend(0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
